// File: rtl/sound_mailbox_ctrl_pkg.sv
// Shared definitions for the 68k<->Z80 sound mailbox controller:
// NMI sequencer state encoding and default parameter values.
package snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } snd_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int NMI_PULSE_DEF   = 8;

endpackage

// File: rtl/sound_mailbox_ctrl_if.sv
// Pin-level bundle between the mailbox controller and the 68k / Z80 decode.
// Handshake: every n* strobe is an asynchronous active-low pulse with no
// ready/ack; a strobe must stay at each level for at least one CLK_24M cycle,
// and the associated data (RW, M68K_DATA_IN, SDD_IN) must be stable from the
// strobe edge until SYNC_STAGES+1 cycles later, when the event takes effect.
interface sound_mailbox_ctrl_if;

  logic       nICOMZONE;
  logic       RW;
  logic [7:0] M68K_DATA_IN;
  logic [7:0] SDD_IN;
  logic       nSDZ80R;
  logic       nSDZ80W;
  logic       nSDZ80CLR;
  logic       nNMI_EN_W;
  logic       nNMI_DIS_W;
  logic [7:0] CMD_DATA;
  logic [7:0] REP_DATA;
  logic       nZ80NMI;
  logic       nSDW;
  logic       CMD_PENDING;
  logic       CMD_OVERRUN;

  // Bus side: 68k / Z80 decode logic.
  modport master (
    output nICOMZONE, RW, M68K_DATA_IN, SDD_IN,
    output nSDZ80R, nSDZ80W, nSDZ80CLR, nNMI_EN_W, nNMI_DIS_W,
    input  CMD_DATA, REP_DATA, nZ80NMI, nSDW, CMD_PENDING, CMD_OVERRUN
  );

  // Controller side.
  modport slave (
    input  nICOMZONE, RW, M68K_DATA_IN, SDD_IN,
    input  nSDZ80R, nSDZ80W, nSDZ80CLR, nNMI_EN_W, nNMI_DIS_W,
    output CMD_DATA, REP_DATA, nZ80NMI, nSDW, CMD_PENDING, CMD_OVERRUN
  );

endinterface

// File: rtl/sound_mailbox_ctrl_strobe_sync.sv
// Synchroniser plus edge detector for one asynchronous active-low strobe.
// Idle level is high, so all flops reset to 1 and no edge is seen at reset.
module strobe_sync
  import snd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchroniser and keep the previous synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~level;
  assign rise  = ~prev_q & level;

endmodule

// File: rtl/sound_mailbox_ctrl.sv
// 68k<->Z80 sound mailbox controller: command/reply latches, pending and
// overrun status, NMI enable and the NMI pulse sequencer.
module sound_mailbox_ctrl
  import snd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int NMI_PULSE   = NMI_PULSE_DEF
) (
  input  logic                 CLK_24M,
  input  logic                 RESET,
  sound_mailbox_ctrl_if.slave  mb,
  output snd_state_e           dbg_state,
  output logic                 dbg_nmi_en
);

  // Strobe index: 0 nICOMZONE, 1 nSDZ80R, 2 nSDZ80W, 3 nSDZ80CLR,
  // 4 nNMI_EN_W, 5 nNMI_DIS_W.
  logic [5:0] raw, lvl, fall, rise;

  assign raw = {mb.nNMI_DIS_W, mb.nNMI_EN_W, mb.nSDZ80CLR,
                mb.nSDZ80W, mb.nSDZ80R, mb.nICOMZONE};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (CLK_24M),
      .rst      (RESET),
      .async_in (raw[g]),
      .level    (lvl[g]),
      .fall     (fall[g]),
      .rise     (rise[g])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{lvl, rise[5:3], rise[1:0], fall[2]};

  logic [SYNC_STAGES-1:0] rw_q;
  logic [7:0]             m68k_q;
  logic [7:0]             sdd_q;

  // RW runs through its own chain so it lines up with the synced nICOMZONE;
  // both data buses get a one-cycle registered copy.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      rw_q   <= '1;
      m68k_q <= 8'h00;
      sdd_q  <= 8'h00;
    end else begin
      rw_q   <= {rw_q[SYNC_STAGES-2:0], mb.RW};
      m68k_q <= mb.M68K_DATA_IN;
      sdd_q  <= mb.SDD_IN;
    end
  end

  logic ev_cmd_wr, ev_cmd_rd, ev_rep_wr, ev_clr, ev_en, ev_dis;

  assign ev_cmd_wr = fall[0] & ~rw_q[SYNC_STAGES-1];
  assign ev_cmd_rd = fall[1];
  assign ev_rep_wr = rise[2];
  assign ev_clr    = fall[3];
  assign ev_en     = fall[4];
  assign ev_dis    = fall[5];

  logic [7:0] cmd_q, rep_q;
  logic       pending_q, overrun_q, sdw_n_q, nmi_en_q;

  // Mailbox latches and status; clear, then read, then write (later wins).
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      cmd_q     <= 8'h00;
      rep_q     <= 8'h00;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      sdw_n_q   <= 1'b1;
    end else begin
      sdw_n_q <= ~ev_cmd_wr;
      if (ev_rep_wr) rep_q <= sdd_q;
      if (ev_clr) begin
        cmd_q     <= 8'h00;
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (ev_cmd_rd) pending_q <= 1'b0;
      if (ev_cmd_wr) begin
        cmd_q     <= m68k_q;
        pending_q <= 1'b1;
        // Overrun only when the old command is still unread after clear/read.
        if (pending_q && !ev_clr && !ev_cmd_rd) overrun_q <= 1'b1;
      end
    end
  end

  // NMI enable flop; disable wins when both arrive together.
  always_ff @(posedge CLK_24M) begin
    if (RESET)       nmi_en_q <= 1'b0;
    else if (ev_dis) nmi_en_q <= 1'b0;
    else if (ev_en)  nmi_en_q <= 1'b1;
  end

  snd_state_e state_q, state_d;
  logic [7:0] cnt_q;
  logic       issued_q;
  logic       enter_pulse;

  // FSM state register.
  always_ff @(posedge CLK_24M) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state. A write while waiting clears issued_q and re-arms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (nmi_en_q && pending_q && !issued_q) state_d = ST_PULSE;
      ST_PULSE: if (cnt_q == 8'd0) state_d = ST_WAIT;
      ST_WAIT:  if (!pending_q || !issued_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: NMI is low only while pulsing.
  always_comb begin
    mb.nZ80NMI = 1'b1;
    if (state_q == ST_PULSE) mb.nZ80NMI = 1'b0;
  end

  assign enter_pulse = (state_q == ST_IDLE) && (state_d == ST_PULSE);

  // Pulse-width counter and the per-command "NMI issued" flag.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      cnt_q    <= 8'd0;
      issued_q <= 1'b0;
    end else begin
      if (enter_pulse)                              cnt_q <= 8'(NMI_PULSE - 1);
      else if (state_q == ST_PULSE && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
      if (ev_cmd_wr)        issued_q <= 1'b0;
      else if (enter_pulse) issued_q <= 1'b1;
    end
  end

  assign mb.CMD_DATA    = cmd_q;
  assign mb.REP_DATA    = rep_q;
  assign mb.nSDW        = sdw_n_q;
  assign mb.CMD_PENDING = pending_q;
  assign mb.CMD_OVERRUN = overrun_q;
  assign dbg_state      = state_q;
  assign dbg_nmi_en     = nmi_en_q;

endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
// Directed bench for sound_mailbox_ctrl (SYNC_STAGES=2, NMI_PULSE=8).
module tb_sound_mailbox_ctrl;
  import snd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  snd_state_e dbg_state;
  logic       dbg_nmi_en;

  int n_checks = 0;
  int n_fails  = 0;
  int low_cnt  = 0;
  int fall_cnt = 0;
  int sdw_cnt  = 0;
  logic prev_nmi = 1'b1;

  sound_mailbox_ctrl_if mb ();

  sound_mailbox_ctrl #(.SYNC_STAGES(2), .NMI_PULSE(8)) dut (
    .CLK_24M    (clk),
    .RESET      (rst),
    .mb         (mb),
    .dbg_state  (dbg_state),
    .dbg_nmi_en (dbg_nmi_en)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 ns after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mb.nZ80NMI === 1'b0) low_cnt++;
      if (mb.nZ80NMI === 1'b0 && prev_nmi === 1'b1) fall_cnt++;
      prev_nmi = mb.nZ80NMI;
      if (mb.nSDW === 1'b0) sdw_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: 0 EN, 1 DIS, 2 CLR, 3 RD
  task automatic pulse_pin(input int which);
    case (which)
      0: mb.nNMI_EN_W  = 1'b0;
      1: mb.nNMI_DIS_W = 1'b0;
      2: mb.nSDZ80CLR  = 1'b0;
      default: mb.nSDZ80R = 1'b0;
    endcase
    tick(4);
    mb.nNMI_EN_W = 1'b1; mb.nNMI_DIS_W = 1'b1;
    mb.nSDZ80CLR = 1'b1; mb.nSDZ80R = 1'b1;
    tick(4);
  endtask

  task automatic wr68k(input logic [7:0] d);
    mb.RW = 1'b0;
    mb.M68K_DATA_IN = d;
    mb.nICOMZONE = 1'b0;
    tick(4);
    mb.nICOMZONE = 1'b1;
    tick(4);
  endtask

  initial begin
    mb.nICOMZONE = 1'b1; mb.RW = 1'b0; mb.M68K_DATA_IN = 8'h00; mb.SDD_IN = 8'h00;
    mb.nSDZ80R = 1'b1; mb.nSDZ80W = 1'b1; mb.nSDZ80CLR = 1'b1;
    mb.nNMI_EN_W = 1'b1; mb.nNMI_DIS_W = 1'b1;

    // Reset values
    tick(3);
    chk("rst_cmd", 32'(mb.CMD_DATA), 32'h00);
    chk("rst_rep", 32'(mb.REP_DATA), 32'h00);
    chk("rst_nmi", 32'(mb.nZ80NMI), 32'h1);
    chk("rst_sdw", 32'(mb.nSDW), 32'h1);
    chk("rst_pend", 32'(mb.CMD_PENDING), 32'h0);
    chk("rst_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    chk("rst_en", 32'(dbg_nmi_en), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick(2);

    // 1: enable, write 0x5A, one nSDW pulse, 8-cycle NMI
    pulse_pin(0);
    chk("t1_en", 32'(dbg_nmi_en), 32'h1);
    low_cnt = 0; fall_cnt = 0; sdw_cnt = 0;
    mb.RW = 1'b0; mb.M68K_DATA_IN = 8'h5A; mb.nICOMZONE = 1'b0;
    tick(2);
    chk("t1_sdw_early", 32'(mb.nSDW), 32'h1);
    chk("t1_cmd_early", 32'(mb.CMD_DATA), 32'h00);
    tick(1);
    chk("t1_sdw_low", 32'(mb.nSDW), 32'h0);
    chk("t1_cmd", 32'(mb.CMD_DATA), 32'h5A);
    chk("t1_pend", 32'(mb.CMD_PENDING), 32'h1);
    chk("t1_nmi_not_yet", 32'(mb.nZ80NMI), 32'h1);
    mb.nICOMZONE = 1'b1;
    tick(1);
    chk("t1_sdw_high", 32'(mb.nSDW), 32'h1);
    chk("t1_nmi_low", 32'(mb.nZ80NMI), 32'h0);
    tick(20);
    chk("t1_nmi_width", 32'(low_cnt), 32'd8);
    chk("t1_nmi_count", 32'(fall_cnt), 32'd1);
    chk("t1_sdw_count", 32'(sdw_cnt), 32'd1);
    chk("t1_wait", 32'(dbg_state), 32'(ST_WAIT));
    mb.nSDZ80R = 1'b0;
    tick(2);
    chk("t1_pend_before_rd", 32'(mb.CMD_PENDING), 32'h1);
    tick(1);
    chk("t1_pend_rd", 32'(mb.CMD_PENDING), 32'h0);
    chk("t1_cmd_hold", 32'(mb.CMD_DATA), 32'h5A);
    tick(1);
    chk("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
    mb.nSDZ80R = 1'b1;
    tick(4);

    // 2: disabled write, no NMI until enable, then exactly one
    pulse_pin(1);
    chk("t2_dis", 32'(dbg_nmi_en), 32'h0);
    low_cnt = 0; fall_cnt = 0;
    wr68k(8'h12);
    tick(50);
    chk("t2_no_nmi", 32'(low_cnt), 32'd0);
    chk("t2_pend", 32'(mb.CMD_PENDING), 32'h1);
    chk("t2_cmd", 32'(mb.CMD_DATA), 32'h12);
    pulse_pin(0);
    tick(16);
    chk("t2_nmi_width", 32'(low_cnt), 32'd8);
    chk("t2_nmi_count", 32'(fall_cnt), 32'd1);
    pulse_pin(3);
    chk("t2_pend_rd", 32'(mb.CMD_PENDING), 32'h0);
    chk("t2_idle", 32'(dbg_state), 32'(ST_IDLE));

    // 3: back-to-back writes -> overrun, second NMI; then clear
    low_cnt = 0; fall_cnt = 0;
    wr68k(8'h01);
    wr68k(8'h02);
    chk("t3_ovr", 32'(mb.CMD_OVERRUN), 32'h1);
    chk("t3_cmd", 32'(mb.CMD_DATA), 32'h02);
    tick(14);
    chk("t3_nmi_count", 32'(fall_cnt), 32'd2);
    chk("t3_nmi_width", 32'(low_cnt), 32'd16);
    pulse_pin(2);
    chk("t3_clr_cmd", 32'(mb.CMD_DATA), 32'h00);
    chk("t3_clr_pend", 32'(mb.CMD_PENDING), 32'h0);
    chk("t3_clr_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    chk("t3_idle", 32'(dbg_state), 32'(ST_IDLE));

    // 4: reply write on rising edge; 68k read does nothing
    mb.SDD_IN = 8'hC3; mb.nSDZ80W = 1'b0;
    tick(4);
    chk("t4_rep_on_fall", 32'(mb.REP_DATA), 32'h00);
    mb.nSDZ80W = 1'b1;
    tick(2);
    chk("t4_rep_early", 32'(mb.REP_DATA), 32'h00);
    tick(1);
    chk("t4_rep", 32'(mb.REP_DATA), 32'hC3);
    sdw_cnt = 0;
    mb.RW = 1'b1; mb.M68K_DATA_IN = 8'h99; mb.nICOMZONE = 1'b0;
    tick(4);
    mb.nICOMZONE = 1'b1;
    tick(4);
    mb.RW = 1'b0;
    chk("t4_rd_sdw", 32'(sdw_cnt), 32'd0);
    chk("t4_rd_cmd", 32'(mb.CMD_DATA), 32'h00);
    chk("t4_rd_pend", 32'(mb.CMD_PENDING), 32'h0);
    chk("t4_rd_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    chk("t4_rd_rep", 32'(mb.REP_DATA), 32'hC3);
    chk("t4_rd_state", 32'(dbg_state), 32'(ST_IDLE));

    // 5: simultaneous events
    pulse_pin(1);
    wr68k(8'h10);
    wr68k(8'h11);
    chk("t5_ovr_pre", 32'(mb.CMD_OVERRUN), 32'h1);
    mb.M68K_DATA_IN = 8'h77; mb.nICOMZONE = 1'b0; mb.nSDZ80CLR = 1'b0;
    tick(3);
    chk("t5_clrwr_cmd", 32'(mb.CMD_DATA), 32'h77);
    chk("t5_clrwr_pend", 32'(mb.CMD_PENDING), 32'h1);
    chk("t5_clrwr_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    mb.nICOMZONE = 1'b1; mb.nSDZ80CLR = 1'b1;
    tick(4);
    mb.M68K_DATA_IN = 8'h88; mb.nICOMZONE = 1'b0; mb.nSDZ80R = 1'b0;
    tick(3);
    chk("t5_rdwr_cmd", 32'(mb.CMD_DATA), 32'h88);
    chk("t5_rdwr_pend", 32'(mb.CMD_PENDING), 32'h1);
    chk("t5_rdwr_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    mb.nICOMZONE = 1'b1; mb.nSDZ80R = 1'b1;
    tick(4);
    pulse_pin(2);
    pulse_pin(0);
    chk("t5_en", 32'(dbg_nmi_en), 32'h1);
    mb.nNMI_EN_W = 1'b0; mb.nNMI_DIS_W = 1'b0;
    tick(3);
    chk("t5_en_dis", 32'(dbg_nmi_en), 32'h0);
    mb.nNMI_EN_W = 1'b1; mb.nNMI_DIS_W = 1'b1;
    tick(4);

    // 6: reset in the third cycle of a pulse
    pulse_pin(0);
    mb.M68K_DATA_IN = 8'hAB; mb.nICOMZONE = 1'b0;
    tick(6);
    chk("t6_pulse", 32'(dbg_state), 32'(ST_PULSE));
    chk("t6_nmi_low", 32'(mb.nZ80NMI), 32'h0);
    rst = 1'b1; mb.nICOMZONE = 1'b1;
    tick(1);
    chk("t6_nmi", 32'(mb.nZ80NMI), 32'h1);
    chk("t6_cmd", 32'(mb.CMD_DATA), 32'h00);
    chk("t6_rep", 32'(mb.REP_DATA), 32'h00);
    chk("t6_sdw", 32'(mb.nSDW), 32'h1);
    chk("t6_pend", 32'(mb.CMD_PENDING), 32'h0);
    chk("t6_ovr", 32'(mb.CMD_OVERRUN), 32'h0);
    chk("t6_en", 32'(dbg_nmi_en), 32'h0);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    low_cnt = 0;
    tick(12);
    chk("t6_quiet", 32'(low_cnt), 32'd0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
